// File: rtl/mix_columns_iter_if.sv
// Handshake bundle for the iterative MixColumns engine: an input block
// channel (valid/ready/inv/state) and an output block channel
// (valid/ready/state). The environment takes the master view and the
// engine takes the slave view.
interface mix_columns_iter_if;
    logic         valid_i;
    logic         ready_o;
    logic         inv_i;
    logic [127:0] state_i;
    logic         valid_o;
    logic         ready_i;
    logic [127:0] state_o;

    modport master (
        output valid_i, inv_i, state_i, ready_i,
        input  ready_o, valid_o, state_o
    );

    modport slave (
        input  valid_i, inv_i, state_i, ready_i,
        output ready_o, valid_o, state_o
    );
endinterface

// File: rtl/mix_columns_iter.sv
// Iterative AES MixColumns / InvMixColumns engine. A 128-bit block is
// latched on accept and COLS_PER_CYCLE columns are transformed in place
// per clock; the finished block is copied to the output register on entry
// to DONE so partially processed columns never appear on state_o.
module mix_columns_iter #(
    parameter int COLS_PER_CYCLE = 4,
    parameter int INV_EN         = 1
) (
    input  logic             clk,
    input  logic             rst,
    mix_columns_iter_if.slave bus
);
    localparam int C = COLS_PER_CYCLE;
    localparam int K = 4 / C;
    localparam logic INV_BIT = (INV_EN != 0);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    generate
        if (!(C == 1 || C == 2 || C == 4)) begin : g_bad_cfg
            $error("mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    // GF(2^8) doubling modulo x^8+x^4+x^3+x+1
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

    // One column; byte 0 sits in the top byte. Inverse coefficients are
    // built from the x2/x4/x8 chain: 9=8+1, B=8+2+1, D=8+4+1, E=8+4+2.
    function automatic logic [31:0] mix_col(input logic [31:0] col, input logic inv);
        logic [3:0][7:0] a;
        logic [3:0][7:0] m2;
        logic [3:0][7:0] m4;
        logic [3:0][7:0] m8;
        logic [3:0][7:0] r;
        logic [1:0]      j1;
        logic [1:0]      j2;
        logic [1:0]      j3;
        a = col;
        for (int i = 0; i < 4; i++) begin
            m2[i] = xtime(a[i]);
            m4[i] = xtime(m2[i]);
            m8[i] = xtime(m4[i]);
        end
        // packed index 3 is byte 0, so "next byte" is index-1
        for (int i = 0; i < 4; i++) begin
            j1 = 2'(i - 1);
            j2 = 2'(i - 2);
            j3 = 2'(i - 3);
            if (inv)
                r[i] = (m8[i] ^ m4[i] ^ m2[i]) ^ (m8[j1] ^ m2[j1] ^ a[j1])
                     ^ (m8[j2] ^ m4[j2] ^ a[j2]) ^ (m8[j3] ^ a[j3]);
            else
                r[i] = m2[i] ^ (m2[j1] ^ a[j1]) ^ a[j2] ^ a[j3];
        end
        return r;
    endfunction

    logic [1:0]   state_q;
    logic [1:0]   cnt_q;
    logic [127:0] blk_q;
    logic [127:0] blk_d;
    logic [127:0] out_q;
    logic         inv_q;
    logic         valid_q;
    logic         run_q;
    logic         ready_c;
    logic         accept;
    logic         last_col;

    logic [6:0]   col_base [C];
    logic [31:0]  col_out  [C];

    // Column lanes: lane gi works on column cnt*C+gi this cycle
    generate
        for (genvar gi = 0; gi < C; gi++) begin : g_col
            logic [1:0] col_sel;
            assign col_sel      = 2'(int'(cnt_q) * C + gi);
            assign col_base[gi] = {~col_sel, 5'd0};
            assign col_out[gi]  = mix_col(blk_q[col_base[gi] +: 32], inv_q);
        end
    endgenerate

    // Write the freshly transformed columns back over the working block
    always_comb begin
        blk_d = blk_q;
        for (int i = 0; i < C; i++) begin
            blk_d[col_base[i] +: 32] = col_out[i];
        end
    end

    // Ready depends only on FSM state and downstream ready; run_q keeps it
    // low during reset and for the first cycle after release
    always_comb begin
        ready_c = 1'b0;
        case (state_q)
            S_IDLE:  ready_c = run_q;
            S_DONE:  ready_c = bus.ready_i;
            default: ready_c = 1'b0;
        endcase
    end

    assign accept   = bus.valid_i & ready_c;
    assign last_col = (cnt_q == 2'(K - 1));

    assign bus.ready_o = ready_c;
    assign bus.valid_o = valid_q;
    assign bus.state_o = out_q;

    // Block FSM: accept, iterate over columns, hold result until taken
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 2'd0;
            blk_q   <= '0;
            out_q   <= '0;
            inv_q   <= 1'b0;
            valid_q <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            run_q <= 1'b1;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        blk_q   <= bus.state_i;
                        inv_q   <= bus.inv_i & INV_BIT;
                        cnt_q   <= 2'd0;
                        state_q <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    blk_q <= blk_d;
                    cnt_q <= cnt_q + 2'd1;
                    if (last_col) begin
                        out_q   <= blk_d;
                        valid_q <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (bus.ready_i) begin
                        valid_q <= 1'b0;
                        if (accept) begin
                            blk_q   <= bus.state_i;
                            inv_q   <= bus.inv_i & INV_BIT;
                            cnt_q   <= 2'd0;
                            state_q <= S_BUSY;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mix_columns_iter.sv
// Directed and randomised bench for mix_columns_iter. Four instances run
// side by side: C=4, C=1, C=2 with the inverse enabled, and C=4 forward-only.
module tb_mix_columns_iter;
    localparam int LANE_C   [4] = '{4, 1, 2, 4};
    localparam int LANE_INV [4] = '{1, 1, 1, 0};

    localparam logic [127:0] FIPS_IN  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    localparam logic [127:0] FIPS_OUT = 128'h046681e5e0cb199a48f8d37a2806264c;
    localparam logic [127:0] COL_IN   = 128'hdb135345f20a225c01010101c6c6c6c6;
    localparam logic [127:0] COL_OUT  = 128'h8e4da1bc9fdc589d01010101c6c6c6c6;

    logic         clk;
    logic         rst;
    logic         vld    [4];
    logic         inv    [4];
    logic         rdy_dn [4];
    logic         rdy_up [4];
    logic         vo     [4];
    logic [127:0] st     [4];
    logic [127:0] so     [4];

    int           n_checks;
    int           n_pass;
    int           cyc;
    logic [127:0] exp_q [$];

    mix_columns_iter_if if0 ();
    mix_columns_iter_if if1 ();
    mix_columns_iter_if if2 ();
    mix_columns_iter_if if3 ();

    assign if0.valid_i = vld[0];  assign if0.inv_i = inv[0];
    assign if0.state_i = st[0];   assign if0.ready_i = rdy_dn[0];
    assign rdy_up[0] = if0.ready_o; assign vo[0] = if0.valid_o; assign so[0] = if0.state_o;
    assign if1.valid_i = vld[1];  assign if1.inv_i = inv[1];
    assign if1.state_i = st[1];   assign if1.ready_i = rdy_dn[1];
    assign rdy_up[1] = if1.ready_o; assign vo[1] = if1.valid_o; assign so[1] = if1.state_o;
    assign if2.valid_i = vld[2];  assign if2.inv_i = inv[2];
    assign if2.state_i = st[2];   assign if2.ready_i = rdy_dn[2];
    assign rdy_up[2] = if2.ready_o; assign vo[2] = if2.valid_o; assign so[2] = if2.state_o;
    assign if3.valid_i = vld[3];  assign if3.inv_i = inv[3];
    assign if3.state_i = st[3];   assign if3.ready_i = rdy_dn[3];
    assign rdy_up[3] = if3.ready_o; assign vo[3] = if3.valid_o; assign so[3] = if3.state_o;

    mix_columns_iter #(.COLS_PER_CYCLE(4), .INV_EN(1)) u_c4 (.clk(clk), .rst(rst), .bus(if0));
    mix_columns_iter #(.COLS_PER_CYCLE(1), .INV_EN(1)) u_c1 (.clk(clk), .rst(rst), .bus(if1));
    mix_columns_iter #(.COLS_PER_CYCLE(2), .INV_EN(1)) u_c2 (.clk(clk), .rst(rst), .bus(if2));
    mix_columns_iter #(.COLS_PER_CYCLE(4), .INV_EN(0)) u_fw (.clk(clk), .rst(rst), .bus(if3));

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Shift-and-add GF(2^8) multiply, independent of any xtime chain
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1B) : (x << 1);
        end
        return p;
    endfunction

    // Reference: r_i = sum_j coef[(j-i) mod 4] * a_j per column
    function automatic logic [127:0] model(input logic [127:0] s, input bit iv);
        logic [7:0]   cf [4];
        logic [7:0]   a  [4];
        logic [7:0]   r;
        logic [127:0] o;
        o = '0;
        if (iv) cf = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        else    cf = '{8'h02, 8'h03, 8'h01, 8'h01};
        for (int c = 0; c < 4; c++) begin
            for (int i = 0; i < 4; i++) a[i] = s[127 - 32*c - 8*i -: 8];
            for (int i = 0; i < 4; i++) begin
                r = 8'h00;
                for (int j = 0; j < 4; j++) r = r ^ gmul(cf[(j - i + 4) % 4], a[j]);
                o[127 - 32*c - 8*i -: 8] = r;
            end
        end
        return o;
    endfunction

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    // Present a block at a negedge and hold it until accepted; flip inv
    // afterwards so a mid-block change would be visible if it leaked in
    task automatic send(input int lane, input logic [127:0] d, input bit iv, output bit to);
        @(negedge clk);
        vld[lane] = 1'b1; st[lane] = d; inv[lane] = iv; to = 1'b1;
        for (int k = 0; k < 50; k++) begin
            if (rdy_up[lane]) begin to = 1'b0; break; end
            @(negedge clk);
        end
        if (!to) @(posedge clk);
        #1;
        vld[lane] = 1'b0;
        inv[lane] = ~iv;
    endtask

    task automatic wait_valid(input int lane, output int lat);
        lat = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            lat++;
            if (vo[lane]) break;
        end
    endtask

    task automatic xfer(input int lane, input logic [127:0] d, input bit iv,
                        input logic [127:0] exp, input string tag, output logic [127:0] got);
        bit to;
        int lat;
        rdy_dn[lane] = 1'b1;
        send(lane, d, iv, to);
        check({tag, "_acc_to"}, 128'(to), 128'(0));
        wait_valid(lane, lat);
        check({tag, "_lat"}, 128'(lat), 128'(4 / LANE_C[lane]));
        check({tag, "_data"}, so[lane], exp);
        got = so[lane];
        $display("xfer %s lane%0d inv=%0d in=%h out=%h lat=%0d", tag, lane, iv, d, so[lane], lat);
        @(posedge clk); #1;
    endtask

    // Continuous source/sink on one lane; exp_q may already hold a result
    // that is pending in DONE when this starts
    task automatic stream(input int lane, input int n, input bit rnd, input bit chk_tp, input bit chk_ovl);
        logic [127:0] din [$];
        bit           iin [$];
        int           n_exp;
        int           got;
        int           last_acc;
        n_exp = n + exp_q.size();
        got = 0;
        last_acc = 0;
        for (int i = 0; i < n; i++) begin
            din.push_back({$urandom, $urandom, $urandom, $urandom});
            iin.push_back(rnd ? bit'($urandom_range(0, 1)) : 1'b0);
        end
        @(posedge clk); #1;
        rdy_dn[lane] = 1'b1;
        fork
            begin : src
                int k;
                for (int i = 0; i < n; i++) begin
                    vld[lane] = 1'b1; st[lane] = din[i]; inv[lane] = iin[i];
                    k = 0;
                    do begin
                        @(negedge clk);
                        k++;
                    end while (!rdy_up[lane] && k < 200);
                    if (!rdy_up[lane]) begin
                        check("src_timeout", 128'(k), 128'(0));
                        break;
                    end
                    if (i == 0 && chk_ovl)
                        check("handoff_same_edge", 128'(vo[lane] & rdy_dn[lane]), 128'(1));
                    if (i > 0 && chk_tp)
                        check("throughput", 128'(cyc - last_acc), 128'(4 / LANE_C[lane] + 1));
                    last_acc = cyc;
                    exp_q.push_back(model(din[i], iin[i] && LANE_INV[lane] != 0));
                    @(posedge clk); #1;
                end
                vld[lane] = 1'b0;
            end
            begin : snk
                int w;
                w = 0;
                while (got < n_exp && w < n * 40 + 100) begin
                    @(negedge clk);
                    w++;
                    if (vo[lane] && rdy_dn[lane]) begin
                        if (exp_q.size() > 0) check("stream_data", so[lane], exp_q.pop_front());
                        else check("stream_extra", so[lane], 128'(0));
                        $display("stream lane%0d blk=%0d out=%h", lane, got, so[lane]);
                        got++;
                    end
                    @(posedge clk); #1;
                    if (rnd) rdy_dn[lane] = ($urandom_range(0, 3) != 0);
                end
                if (got < n_exp) check("snk_timeout", 128'(got), 128'(n_exp));
            end
        join
        rdy_dn[lane] = 1'b1;
        exp_q.delete();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] y;
        logic [127:0] x;
        bit           to;
        int           lat;
        bit           seen;
        n_checks = 0;
        n_pass   = 0;
        cyc      = 0;
        for (int l = 0; l < 4; l++) begin
            vld[l] = 1'b0; inv[l] = 1'b0; rdy_dn[l] = 1'b1; st[l] = '0;
        end

        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid_o", 128'(vo[0]), 128'(0));
        check("rst_state_o", so[1], 128'(0));
        check("rst_ready_o", 128'(rdy_up[2]), 128'(0));
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        check("idle_ready_o", 128'(rdy_up[0]), 128'(1));
        check("idle_valid_o", 128'(vo[3]), 128'(0));

        // FIPS-197 vector forward and inverse, all widths
        xfer(0, FIPS_IN,  1'b0, FIPS_OUT, "fips_fwd_c4", y);
        xfer(0, FIPS_OUT, 1'b1, FIPS_IN,  "fips_inv_c4", y);
        xfer(3, FIPS_IN,  1'b1, FIPS_OUT, "inv_disabled", y);
        xfer(1, COL_IN,   1'b0, COL_OUT,  "cols_fwd_c1", y);
        xfer(2, COL_IN,   1'b0, COL_OUT,  "cols_fwd_c2", y);
        xfer(1, COL_OUT,  1'b1, COL_IN,   "cols_inv_c1", y);
        xfer(2, FIPS_OUT, 1'b1, FIPS_IN,  "fips_inv_c2", y);

        // Backpressure: result held in DONE, no new accept
        rdy_dn[0] = 1'b0;
        send(0, FIPS_IN, 1'b0, to);
        check("bp_acc_to", 128'(to), 128'(0));
        wait_valid(0, lat);
        check("bp_lat", 128'(lat), 128'(1));
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("bp_hold_data", so[0], FIPS_OUT);
            check("bp_ready_low", 128'(rdy_up[0]), 128'(0));
        end
        exp_q.push_back(FIPS_OUT);
        stream(0, 9, 1'b0, 1'b1, 1'b1);

        // Reset while BUSY at column 2 of a C=1 block
        rdy_dn[1] = 1'b1;
        send(1, COL_IN, 1'b0, to);
        @(posedge clk); @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("midrst_valid_o", 128'(vo[1]), 128'(0));
        check("midrst_state_o", so[1], 128'(0));
        @(posedge clk); #1 rst = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            seen = seen | vo[1];
        end
        check("midrst_no_output", 128'(seen), 128'(0));
        xfer(1, COL_IN, 1'b0, COL_OUT, "after_rst_c1", y);

        // Round trips through the DUT itself
        for (int l = 0; l < 3; l++) begin
            x = {$urandom, $urandom, $urandom, $urandom};
            xfer(l, x, 1'b1, model(x, 1'b1), "rt_inv", y);
            xfer(l, y, 1'b0, x, "rt_fwd", y);
        end

        // Randomised traffic with random downstream ready, 200 blocks
        stream(0, 60, 1'b1, 1'b0, 1'b0);
        stream(1, 50, 1'b1, 1'b0, 1'b0);
        stream(2, 50, 1'b1, 1'b0, 1'b0);
        stream(3, 40, 1'b1, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
